// File: rtl/instruction_decode_queue_if.sv
// Bundle of every non-clock/reset signal of instruction_decode_queue.
//   master : upstream producer / RAM / writeback / EXE side (drives the i* signals)
//   slave  : the decode queue itself (drives the o* signals)
// Signals:
//   iInstruction/iInstructionValid/oInstructionReady : instruction push handshake
//   iFlush                                           : synchronous discard
//   oRamAddress0/1, iRamValue0/1                     : combinational-read RAM port
//   iFwdValid/iFwdAddress/iFwdData                   : writeback forwarding ports
//   oValid/iExeReady + oOperation/oDestination/oSource0/oSource1 : EXE handshake
//   oOccupancy                                       : queue entry count
interface instruction_decode_queue_if #(
  parameter int OP_WIDTH   = 6,
  parameter int ADDR_WIDTH = 16,
  parameter int ROW_WIDTH  = 96,
  parameter int DEPTH      = 2,
  parameter int FWD_PORTS  = 2
);
  localparam int IW = OP_WIDTH + 3 * ADDR_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0]                   iInstruction;
  logic                            iInstructionValid;
  logic                            oInstructionReady;
  logic                            iFlush;
  logic [ADDR_WIDTH-1:0]           oRamAddress0;
  logic [ADDR_WIDTH-1:0]           oRamAddress1;
  logic [ROW_WIDTH-1:0]            iRamValue0;
  logic [ROW_WIDTH-1:0]            iRamValue1;
  logic [FWD_PORTS-1:0]            iFwdValid;
  logic [FWD_PORTS*ADDR_WIDTH-1:0] iFwdAddress;
  logic [FWD_PORTS*ROW_WIDTH-1:0]  iFwdData;
  logic                            oValid;
  logic                            iExeReady;
  logic [OP_WIDTH-1:0]             oOperation;
  logic [ADDR_WIDTH-1:0]           oDestination;
  logic [ROW_WIDTH-1:0]            oSource0;
  logic [ROW_WIDTH-1:0]            oSource1;
  logic [CW-1:0]                   oOccupancy;

  modport master (
    output iInstruction, iInstructionValid, iFlush, iRamValue0, iRamValue1,
           iFwdValid, iFwdAddress, iFwdData, iExeReady,
    input  oInstructionReady, oRamAddress0, oRamAddress1, oValid,
           oOperation, oDestination, oSource0, oSource1, oOccupancy
  );

  modport slave (
    input  iInstruction, iInstructionValid, iFlush, iRamValue0, iRamValue1,
           iFwdValid, iFwdAddress, iFwdData, iExeReady,
    output oInstructionReady, oRamAddress0, oRamAddress1, oValid,
           oOperation, oDestination, oSource0, oSource1, oOccupancy
  );
endinterface

// File: rtl/instruction_decode_queue.sv
// Instruction decode queue: a small circular FIFO of encoded instructions
// {op, dest, src1, src0}. The head slot drives the RAM read addresses; in the
// pop cycle the operands are resolved (immediate packing, writeback
// forwarding with lowest port winning) and captured in the EXE output register.
// Ports:
//   Clock : rising-edge clock
//   Reset : asynchronous, active-high reset
//   bus   : instruction_decode_queue_if.slave (push, RAM, forwarding, EXE)
module instruction_decode_queue #(
  parameter int OP_WIDTH   = 6,
  parameter int ADDR_WIDTH = 16,
  parameter int ROW_WIDTH  = 96,
  parameter int DEPTH      = 2,
  parameter int FWD_PORTS  = 2,
  parameter int IMM_BIT    = 5
) (
  input  logic                       Clock,
  input  logic                       Reset,
  instruction_decode_queue_if.slave  bus
);
  localparam int IW = OP_WIDTH + 3 * ADDR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0]         slots [DEPTH];
  logic [PW-1:0]         rdPtr, wrPtr;
  logic [CW-1:0]         count;

  logic                  valid;
  logic [OP_WIDTH-1:0]   operation;
  logic [ADDR_WIDTH-1:0] destination;
  logic [ROW_WIDTH-1:0]  source0, source1;

  logic                  empty, ready, push, pop;
  logic [OP_WIDTH-1:0]   headOp;
  logic [ADDR_WIDTH-1:0] headDest, headSrc1, headSrc0;
  logic                  headImm;
  logic [ADDR_WIDTH-1:0] ramAddr0, ramAddr1;
  logic [ROW_WIDTH-1:0]  fwd0, fwd1, immRow, src1Next;
  logic                  hit0, hit1;

  assign empty = (count == '0);
  assign ready = (count < CW'(DEPTH)) && !Reset;
  assign push  = bus.iInstructionValid && ready && !bus.iFlush;
  assign pop   = !empty && (!valid || bus.iExeReady) && !bus.iFlush;

  assign {headOp, headDest, headSrc1, headSrc0} = slots[rdPtr];
  assign headImm  = headOp[IMM_BIT] || (headOp == '0);
  assign ramAddr0 = empty ? '0 : (headImm ? headDest : headSrc0);
  assign ramAddr1 = empty ? '0 : headSrc1;

  // Forwarding: scan ports upward, first hit locks so the lowest port wins.
  always_comb begin
    fwd0 = bus.iRamValue0;
    fwd1 = bus.iRamValue1;
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int unsigned k = 0; k < FWD_PORTS; k++) begin
      if (!hit0 && bus.iFwdValid[k] &&
          bus.iFwdAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == ramAddr0) begin
        fwd0 = bus.iFwdData[k*ROW_WIDTH +: ROW_WIDTH];
        hit0 = 1'b1;
      end
      if (!hit1 && bus.iFwdValid[k] &&
          bus.iFwdAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == ramAddr1) begin
        fwd1 = bus.iFwdData[k*ROW_WIDTH +: ROW_WIDTH];
        hit1 = 1'b1;
      end
    end
  end

  // Immediate operand packs {src1, src0} into the top of the row, zero below.
  always_comb begin
    immRow = '0;
    immRow[ROW_WIDTH-1 -: 2*ADDR_WIDTH] = {headSrc1, headSrc0};
    src1Next = headImm ? immRow : fwd1;
  end

  // Slot storage needs no reset: occupancy/pointers define which slots are live.
  always_ff @(posedge Clock) begin
    if (push) slots[wrPtr] <= bus.iInstruction;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      valid       <= 1'b0;
      operation   <= '0;
      destination <= '0;
      source0     <= '0;
      source1     <= '0;
    end else if (bus.iFlush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) begin
        rdPtr       <= rdPtr + PW'(1);
        valid       <= 1'b1;
        operation   <= headOp;
        destination <= headDest;
        source0     <= fwd0;
        source1     <= src1Next;
      end else if (bus.iExeReady) begin
        valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.oInstructionReady = ready;
  assign bus.oRamAddress0      = ramAddr0;
  assign bus.oRamAddress1      = ramAddr1;
  assign bus.oValid            = valid;
  assign bus.oOperation        = operation;
  assign bus.oDestination      = destination;
  assign bus.oSource0          = source0;
  assign bus.oSource1          = source1;
  assign bus.oOccupancy        = count;
endmodule

// File: tb/tb_instruction_decode_queue.sv
// Self-checking bench for instruction_decode_queue: directed scenarios followed
// by a randomized phase, all compared against a queue-based reference model.
module tb_instruction_decode_queue;
  localparam int OPW  = 6;
  localparam int AW   = 16;
  localparam int RW   = 96;
  localparam int D    = 2;
  localparam int FP   = 2;
  localparam int IMMB = 5;
  localparam int IW   = OPW + 3 * AW;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  instruction_decode_queue_if #(.OP_WIDTH(OPW), .ADDR_WIDTH(AW), .ROW_WIDTH(RW),
                                .DEPTH(D), .FWD_PORTS(FP)) bus ();

  instruction_decode_queue #(.OP_WIDTH(OPW), .ADDR_WIDTH(AW), .ROW_WIDTH(RW),
                             .DEPTH(D), .FWD_PORTS(FP), .IMM_BIT(IMMB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  function automatic logic [RW-1:0] ramFn(input logic [AW-1:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return {16'hA5A5, a, h, 16'hC3C3, ~a};
  endfunction

  // RAM model: combinational read
  assign bus.iRamValue0 = ramFn(bus.oRamAddress0);
  assign bus.iRamValue1 = ramFn(bus.oRamAddress1);

  // Reference model state
  logic [IW-1:0]  mq[$];
  logic           mValid;
  logic [OPW-1:0] mOp;
  logic [AW-1:0]  mDest;
  logic [RW-1:0]  mS0, mS1;
  bit             lastPush;

  int passCnt = 0;
  int failCnt = 0;
  int totalCnt = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] fwdPick(input logic [AW-1:0] a, input logic [RW-1:0] ram);
    for (int k = 0; k < FP; k++)
      if (bus.iFwdValid[k] && bus.iFwdAddress[k*AW +: AW] == a)
        return bus.iFwdData[k*RW +: RW];
    return ram;
  endfunction

  function automatic logic [IW-1:0] mkInstr(input logic [OPW-1:0] op, input logic [AW-1:0] d,
                                            input logic [AW-1:0] s1, input logic [AW-1:0] s0);
    return {op, d, s1, s0};
  endfunction

  // One clock: called at posedge+1; checks at negedge, model commits after posedge.
  task automatic cycle(input bit randFwd);
    logic [IW-1:0]  h, inst;
    logic [OPW-1:0] op, nOp;
    logic [AW-1:0]  dst, s1, s0, a0, a1, nDest;
    logic [RW-1:0]  nS0, nS1;
    bit imm, empty, push, pop, flush, nValid;
    @(negedge Clock);
    empty = (mq.size() == 0);
    h = empty ? '0 : mq[0];
    op = h[IW-1 -: OPW]; dst = h[3*AW-1 -: AW]; s1 = h[2*AW-1 -: AW]; s0 = h[AW-1:0];
    imm = op[IMMB] || (op == 0);
    a0 = empty ? '0 : (imm ? dst : s0);
    a1 = empty ? '0 : s1;
    if (randFwd) begin
      for (int k = 0; k < FP; k++) begin
        bus.iFwdValid[k] = 1'($urandom);
        case ($urandom_range(0, 2))
          0: bus.iFwdAddress[k*AW +: AW] = a0;
          1: bus.iFwdAddress[k*AW +: AW] = a1;
          default: bus.iFwdAddress[k*AW +: AW] = 16'($urandom);
        endcase
        bus.iFwdData[k*RW +: RW] = {$urandom, $urandom, $urandom};
      end
    end
    #1;
    chk("ready", bus.oInstructionReady, mq.size() < D);
    chk("occupancy", bus.oOccupancy, RW'(mq.size()));
    chk("ramAddr0", bus.oRamAddress0, a0);
    chk("ramAddr1", bus.oRamAddress1, a1);
    chk("valid", bus.oValid, mValid);
    chk("operation", bus.oOperation, mOp);
    chk("destination", bus.oDestination, mDest);
    chk("source0", bus.oSource0, mS0);
    chk("source1", bus.oSource1, mS1);
    flush = bus.iFlush;
    inst = bus.iInstruction;
    push = bus.iInstructionValid && (mq.size() < D) && !flush;
    pop = !empty && (!mValid || bus.iExeReady) && !flush;
    nValid = mValid; nOp = mOp; nDest = mDest; nS0 = mS0; nS1 = mS1;
    if (flush) nValid = 0;
    else if (pop) begin
      nValid = 1; nOp = op; nDest = dst;
      nS0 = fwdPick(a0, ramFn(a0));
      nS1 = imm ? {s1, s0, {(RW-2*AW){1'b0}}} : fwdPick(a1, ramFn(a1));
    end else if (bus.iExeReady) nValid = 0;
    @(posedge Clock);
    #1;
    mValid = nValid; mOp = nOp; mDest = nDest; mS0 = nS0; mS1 = nS1;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(inst);
    end
    lastPush = push;
  endtask

  task automatic pushOne(input logic [IW-1:0] inst);
    bus.iInstruction = inst;
    bus.iInstructionValid = 1'b1;
    cycle(0);
    bus.iInstructionValid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_ready"}, bus.oInstructionReady, 0);
    chk({tag, "_valid"}, bus.oValid, 0);
    chk({tag, "_occ"}, bus.oOccupancy, 0);
    chk({tag, "_op"}, bus.oOperation, 0);
    chk({tag, "_dest"}, bus.oDestination, 0);
    chk({tag, "_s0"}, bus.oSource0, 0);
    chk({tag, "_s1"}, bus.oSource1, 0);
    chk({tag, "_addr0"}, bus.oRamAddress0, 0);
  endtask

  task automatic modelClear();
    mq.delete();
    mValid = 0; mOp = '0; mDest = '0; mS0 = '0; mS1 = '0;
  endtask

  logic [RW-1:0] p0, p1;
  int guard;

  initial begin
    Reset = 1'b1;
    bus.iInstruction = '0; bus.iInstructionValid = 1'b0; bus.iFlush = 1'b0;
    bus.iExeReady = 1'b0; bus.iFwdValid = '0; bus.iFwdAddress = '0; bus.iFwdData = '0;
    modelClear();
    #1;
    checkAllZero("reset_init");
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    chk("ready_after_reset", bus.oInstructionReady, 1);

    // Single non-immediate instruction, latency 2 edges
    bus.iExeReady = 1'b1;
    pushOne(mkInstr(6'h01, 16'h0010, 16'h0021, 16'h0020));
    chk("t041_valid_edge1", bus.oValid, 0);
    cycle(0);
    chk("t041_valid_edge2", bus.oValid, 1);
    chk("t041_dest", bus.oDestination, 16'h0010);
    chk("t041_s0", bus.oSource0, ramFn(16'h0020));
    chk("t041_s1", bus.oSource1, ramFn(16'h0021));

    // Immediate packing
    pushOne(mkInstr(6'h20, 16'h0030, 16'h1234, 16'h5678));
    chk("t042_addr0", bus.oRamAddress0, 16'h0030);
    cycle(0);
    chk("t042_s1", bus.oSource1, 96'h1234_5678_0000_0000_0000_0000);

    // Forwarding priority
    p0 = 96'h0000_1111_2222_3333_4444_5555;
    p1 = 96'h6666_7777_8888_9999_AAAA_BBBB;
    bus.iFwdValid = 2'b11;
    bus.iFwdAddress = {16'h0020, 16'h0020};
    bus.iFwdData = {p1, p0};
    pushOne(mkInstr(6'h01, 16'h0011, 16'h0040, 16'h0020));
    cycle(0);
    chk("t043_both_port0", bus.oSource0, p0);
    bus.iFwdValid = 2'b10;
    pushOne(mkInstr(6'h02, 16'h0012, 16'h0041, 16'h0020));
    cycle(0);
    chk("t043_port1", bus.oSource0, p1);
    bus.iFwdValid = 2'b01;
    bus.iFwdAddress = {16'h0000, 16'h0060};
    pushOne(mkInstr(6'h21, 16'h0050, 16'h0060, 16'h0070));
    cycle(0);
    chk("t043_imm_nofwd", bus.oSource1, 96'h0060_0070_0000_0000_0000_0000);
    bus.iFwdValid = '0;
    cycle(0);

    // Backpressure
    bus.iExeReady = 1'b0;
    pushOne(mkInstr(6'h03, 16'h0101, 16'h0201, 16'h0301));
    pushOne(mkInstr(6'h04, 16'h0102, 16'h0202, 16'h0302));
    pushOne(mkInstr(6'h05, 16'h0103, 16'h0203, 16'h0303));
    bus.iInstruction = mkInstr(6'h06, 16'h0104, 16'h0204, 16'h0304);
    bus.iInstructionValid = 1'b1;
    repeat (3) cycle(0);
    chk("t044_ready", bus.oInstructionReady, 0);
    chk("t044_occ", bus.oOccupancy, 2);
    chk("t044_hold_dest", bus.oDestination, 16'h0101);
    bus.iExeReady = 1'b1;
    lastPush = 0;
    guard = 0;
    while (!lastPush && guard < 8) begin
      cycle(0);
      guard++;
    end
    chk("t044_push_timeout", lastPush, 1);
    bus.iInstructionValid = 1'b0;
    repeat (5) cycle(0);

    // Flush with simultaneous push
    bus.iExeReady = 1'b0;
    pushOne(mkInstr(6'h07, 16'h0111, 16'h0211, 16'h0311));
    pushOne(mkInstr(6'h08, 16'h0112, 16'h0212, 16'h0312));
    pushOne(mkInstr(6'h09, 16'h0113, 16'h0213, 16'h0313));
    chk("t045_pre_occ", bus.oOccupancy, 2);
    chk("t045_pre_valid", bus.oValid, 1);
    bus.iFlush = 1'b1;
    pushOne(mkInstr(6'h0A, 16'h0BAD, 16'h0214, 16'h0314));
    bus.iFlush = 1'b0;
    chk("t045_occ", bus.oOccupancy, 0);
    chk("t045_valid", bus.oValid, 0);
    bus.iExeReady = 1'b1;
    repeat (3) cycle(0);

    // Asynchronous reset while full
    bus.iExeReady = 1'b0;
    pushOne(mkInstr(6'h0B, 16'h0121, 16'h0221, 16'h0321));
    pushOne(mkInstr(6'h0C, 16'h0122, 16'h0222, 16'h0322));
    pushOne(mkInstr(6'h0D, 16'h0123, 16'h0223, 16'h0323));
    chk("t046_full", bus.oOccupancy, 2);
    #2;
    Reset = 1'b1;
    #1;
    checkAllZero("t046_async");
    modelClear();
    @(posedge Clock); #3;
    Reset = 1'b0;
    @(posedge Clock); #1;
    chk("t046_ready", bus.oInstructionReady, 1);
    chk("t046_occ", bus.oOccupancy, 0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      bus.iInstructionValid = 1'($urandom);
      bus.iInstruction = mkInstr(($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom),
                                 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                                 16'($urandom_range(0, 15)));
      bus.iExeReady = ($urandom_range(0, 3) != 0);
      bus.iFlush = ($urandom_range(0, 15) == 0);
      cycle(1);
    end
    bus.iFlush = 1'b0;
    bus.iInstructionValid = 1'b0;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
